// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the ID stage and the hazard controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [REG_W-1:0] id_rd;
   logic             id_we;
   logic             id_is_load;
   logic             mem_stall;
   logic             flush;
   logic [1:0]       fwd_sel_rs1;
   logic [1:0]       fwd_sel_rs2;
   logic             stall_if;
   logic             stall_id;
   logic             bubble_exe;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_we, id_is_load, mem_stall, flush,
      input  fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_id, bubble_exe, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_we, id_is_load, mem_stall, flush,
      output fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_id, bubble_exe, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use stalls and stall counting.
// Define HAZARD_FWD_EN to enable forwarding; otherwise every RAW dependency stalls.
package CorePack;
   typedef enum logic [1:0] {
      FWD_NO  = 2'd0,
      FWD_EXE = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_enum;
endpackage

module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);
   import CorePack::*;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             ld;
   } shadow_t;

   // Index 0 = EXE, 1 = MEM, 2 = WB; the order is also the match priority.
   shadow_t          stg [3];
   logic [CNT_W-1:0] cnt_q;

   logic       haz_rs1, haz_rs2, hazard;
   logic [1:0] sel_rs1, sel_rs2;

   // Stage index i maps onto select encoding i+1 (EXE, MEM, WB); only EXE/MEM loads block.
   function automatic logic [2:0] resolve(input logic used, input logic [REG_W-1:0] src,
                                          input shadow_t st [3]);
      logic       found;
      logic       haz;
      logic [1:0] sel;
      found = 1'b0;
      haz   = 1'b0;
      sel   = FWD_NO;
      for (int i = 0; i < 3; i++) begin
         if (!found && used && st[i].v && st[i].we && (st[i].rd == src) && (src != '0)) begin
            found = 1'b1;
            sel   = 2'(i + 1);
            haz   = st[i].ld && (i < 2);
         end
      end
`ifndef HAZARD_FWD_EN
      haz = found;
      sel = FWD_NO;
`endif
      return {haz, sel};
   endfunction

   always_comb begin
      {haz_rs1, sel_rs1} = resolve(bus.id_valid & bus.id_rs1_used, bus.id_rs1, stg);
      {haz_rs2, sel_rs2} = resolve(bus.id_valid & bus.id_rs2_used, bus.id_rs2, stg);
   end

   assign hazard          = haz_rs1 | haz_rs2;
   assign bus.fwd_sel_rs1 = sel_rs1;
   assign bus.fwd_sel_rs2 = sel_rs2;
   assign bus.stall_id    = hazard & ~bus.flush;
   assign bus.stall_if    = hazard & ~bus.flush;
   assign bus.bubble_exe  = (hazard | bus.flush) & ~bus.mem_stall;
   assign bus.stall_cnt   = cnt_q;

   // A bubble replaces the ID instruction with an invalid entry; mem_stall freezes everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg[0] <= '0;
         stg[1] <= '0;
         stg[2] <= '0;
      end else if (!bus.mem_stall) begin
         if (bus.bubble_exe)
            stg[0] <= '0;
         else
            stg[0] <= {bus.id_valid, bus.id_rd, bus.id_we, bus.id_is_load};
         stg[1] <= stg[0];
         stg[2] <= stg[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (bus.stall_id && !bus.mem_stall && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It keeps a shadow record of the destination register, write-enable and load flag of the instructions in EXE, MEM and WB. From that record it drives the `fwd_sel_enum` selects of the two ID-stage register-data forwarding muxes (rs1, rs2). It also generates load-use stalls, EXE bubbles and a stall-cycle count.

## Interface
Parameters:
- `REG_W`, default 5: register index width.
- `CNT_W`, default 32: stall counter width.

Ports:
- `clk`  in  1  core clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_W each  source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the source is actually read.
- `id_rd`  in  REG_W  destination register index.
- `id_we`  in  1  the instruction writes the register file.
- `id_is_load`  in  1  the instruction is a load.
- `mem_stall`  in  1  data memory not ready; freezes the whole pipeline.
- `flush`  in  1  branch/jump redirect resolved in EXE; kills the ID instruction.
- `fwd_sel_rs1`, `fwd_sel_rs2`  out  2 each  `CorePack::fwd_sel_enum`: `FWD_NO`, `FWD_EXE`, `FWD_MEM`, `FWD_WB`.
- `stall_if`, `stall_id`  out  1 each  hold the PC and the IF/ID register.
- `bubble_exe`  out  1  load NOP into ID/EXE.
- `stall_cnt`  out  CNT_W  number of hazard stall cycles.

## Operation
- Shadow stages: EXE, MEM and WB. Each holds `{v, rd, we, ld}`.
- Writer match: a stage `s` is a writer of register `r` when `v_s & we_s & rd_s==r & r!=0`. x0 never matches.
- Per-source hazard, for each used source with `id_valid`, checking stages in priority order EXE > MEM > WB. The first writer match decides:
  - EXE match with `ld` → hazard (load data not yet available).
  - MEM match with `ld` → hazard (`alu_res_mem` holds an address, not data).
  - Otherwise → forward from the matching stage.
  - No match → `FWD_NO`.
- `hazard` = rs1 hazard | rs2 hazard.
- `stall_id = stall_if = hazard & ~flush`.
- `bubble_exe = (hazard | flush) & ~mem_stall`.
- While `hazard` is asserted, the `fwd_sel` outputs still show the computed select. The downstream stage ignores them, because a bubble is issued.
- Shadow update at posedge, in priority order:
  - `rst`: all `v=0`.
  - else `mem_stall`: all stages hold.
  - else `bubble_exe`: EXE←invalid, MEM←EXE, WB←MEM.
  - else: EXE←`{id_valid, id_rd, id_we, id_is_load}`, MEM←EXE, WB←MEM.
- `stall_cnt`:
  - Increments when `stall_id & ~mem_stall`.
  - Saturates at all-ones.
  - Cleared by `rst`.

## Timing
- `fwd_sel_*`, `stall_*` and `bubble_exe` are combinational from the ID inputs and the shadow registers, valid in the same cycle. There are no timing paths through `stall_cnt`.
- Shadow state and `stall_cnt` change only on the `clk` rising edge.
- Reset values: all shadows invalid, so `fwd_sel_*=FWD_NO`, `stall_*=0`, `bubble_exe=0` and `stall_cnt=0` in the cycle after `rst`.
- Load-use latency:
  - Consumer directly behind a load: 2 stall cycles, then `FWD_WB`.
  - One independent instruction between load and consumer: 1 stall cycle, then `FWD_WB`.
- Simultaneous events:
  - `flush` with `hazard`: `flush` wins. No stall; bubble issued.
  - `mem_stall` with anything: shadows frozen, `stall_cnt` frozen, outputs stay consistent with the frozen state.
- `rst` mid-stall: invalidates every stage. The hazard drops in the next cycle.

## Configuration
- Macro `HAZARD_FWD_EN`.
- Defined: forwarding operates as described above.
- Undefined:
  - `fwd_sel_*` are tied to `FWD_NO`.
  - Any used-source writer match in EXE, MEM or WB (not only loads) is a hazard.
  - A dependent instruction directly behind its producer therefore stalls 3 cycles.

## Test plan
- `add x1` then `add x2,x1,x1` back-to-back → `fwd_sel_rs1=fwd_sel_rs2=FWD_EXE`, `stall_id=0`.
- `lw x5` then `add x6,x5,x0` → `stall_id=1` for 2 cycles with `bubble_exe=1`, then `fwd_sel_rs1=FWD_WB`; `stall_cnt=2`.
- x3 written by instructions in EXE and in MEM, reader of x3 in ID → `FWD_EXE`. Writer to x0 followed by a reader of x0 → `FWD_NO`, no stall.
- Load-use hazard with `flush=1` in the same cycle → `stall_id=0`, `bubble_exe=1`, and the EXE shadow is invalid next cycle.
- Load-use hazard with `mem_stall` held 3 cycles → outputs and `stall_cnt` unchanged for those cycles, then the 2 stall cycles proceed normally.
- `rst` asserted during a stall → next cycle `stall_id=0`, `fwd_sel_*=FWD_NO`, `stall_cnt=0`. With `HAZARD_FWD_EN` undefined, the `add`-`add` pair → 3 stall cycles, `FWD_NO`.
